store_sequencer: RTL and testbench
==================================

Name: store_sequencer

Overview:
Multicycle controller that sequences memory stores for sw/sh/sb.
- sw: writes the full register-B word directly.
- sh/sb: read-modify-write. Reads the current memory word, merges the low 16 or 8 bits of register B into it, then writes the merged word back.
- Sits between the main control unit and the memory port. It owns mem_addr/mem_wr during a store and returns a one-cycle done pulse.

Parameters:
- MEM_LAT, 2, cycles from the read address being presented (mem_wr=0) to valid mem_rdata; legal range 1..15.
- CNT_W, 4, width of the read-latency counter; must hold MEM_LAT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  store request; sampled only in IDLE.
- store_type  input  2  00=sw, 01=sh, 10=sb, 11=illegal.
- addr  input  32  store address; latched at start.
- regB  input  32  store data source; latched at start.
- mem_rdata  input  32  memory read data.
- mem_addr  output  32  memory address; holds the latched addr whenever busy.
- mem_wr  output  1  memory write strobe; one cycle per store.
- mem_wdata  output  32  write data; valid while mem_wr=1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at store completion.
- error  output  1  one-cycle pulse together with done for an illegal store_type.

Behaviour:
- Reset (async, active-high): state=IDLE; mem_addr, mem_wdata and internal latches are 0; mem_wr, busy, done and error are 0. Reset mid-operation aborts the store and no write is issued.
- States: IDLE, READ_WAIT, WRITE, DONE.
- IDLE, start=1: latch addr, regB and store_type.
  - type 00 -> WRITE.
  - type 01/10 -> READ_WAIT, counter cleared.
  - type 11 -> DONE with the error flag set.
- READ_WAIT:
  - mem_wr=0, mem_addr=latched addr.
  - Counter increments each cycle.
  - When counter==MEM_LAT-1: capture mem_rdata into the merge register and go to WRITE. The state therefore lasts exactly MEM_LAT cycles.
- Merge rule (low-lane replacement, no byte steering by addr[1:0]):
  - sh: {mem[31:16], regB[15:0]}.
  - sb: {mem[31:8], regB[7:0]}.
  - sw: regB.
- WRITE: mem_wr=1 for exactly one cycle, mem_wdata=merged word, mem_addr=latched addr; then go to DONE.
- DONE: done=1 for one cycle; error=1 only for type 11; then go to IDLE.
- Latency, with start sampled at edge 0:
  - sw: mem_wr in cycle 1, done in cycle 2.
  - sh/sb: READ_WAIT in cycles 1..MEM_LAT, mem_wr in cycle MEM_LAT+1, done in cycle MEM_LAT+2.
  - illegal: done+error in cycle 1, with no memory access.
- start while busy: ignored, not queued.
- start in the same cycle done is high: ignored, because the FSM is still in DONE. The earliest accepted new start is the cycle after done.
- Latched inputs are stable for the whole operation. Changes to addr/regB/store_type after start have no effect.
- mem_wdata is 0 outside WRITE.
- mem_addr keeps its last value while in IDLE.

Test Plan:
- sw, regB=0xAAAA1234, addr=0x40 -> mem_wr=1 in cycle 1 with mem_wdata=0xAAAA1234 and mem_addr=0x40; done in cycle 2; no read phase.
- sh, MEM_LAT=2, memory[0x40]=0xDEADBEEF, regB=0xAAAA1234 -> READ_WAIT for cycles 1-2; write 0xDEAD1234 in cycle 3; done in cycle 4.
- sb, same setup -> write 0xDEADBE34; then a sw back-to-back, with start the cycle after done, is accepted and writes 0xAAAA1234.
- store_type=11 -> done=1 and error=1 in cycle 1; mem_wr never asserted.
- start pulsed again during READ_WAIT with different regB -> ignored; the original merged word is written; exactly one done.
- reset asserted in cycle 2 of an sh READ_WAIT -> all outputs 0 immediately; no mem_wr ever issued; after release, a new sw completes normally.

Source files
------------

// File: rtl/store_sequencer.sv
// Store sequencer: drives the memory port for sw (direct write) and sh/sb
// (read-modify-write into the low lane of the word), then pulses done.
module store_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] regB,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE,
    DONE
  } state_e;

  localparam logic [1:0] TYPE_SW = 2'b00;
  localparam logic [1:0] TYPE_SH = 2'b01;
  localparam logic [1:0] TYPE_SB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       type_q;
  logic [15:0]      regb_lo_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             mem_wr_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [31:0]      merge_d;

  // Low-lane replacement only; addr[1:0] never steers the byte/half position.
  // NOTE: merge_d gets a full default first so no path leaves it unassigned (no latch).
  always_comb begin
    merge_d = mem_rdata;
    if (type_q == TYPE_SH) begin
      merge_d[15:0] = regb_lo_q;
    end else if (type_q == TYPE_SB) begin
      merge_d[7:0] = regb_lo_q[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= TYPE_SW;
      regb_lo_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; non-blocking so every
      // branch below sees the pre-edge values of all state registers.
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            mem_addr_q <= addr;
            regb_lo_q  <= regB[15:0];
            type_q     <= store_type;
            busy_q     <= 1'b1;
            unique case (store_type)
              TYPE_SW: begin
                state_q     <= WRITE;
                mem_wr_q    <= 1'b1;
                mem_wdata_q <= regB;
              end
              TYPE_SH, TYPE_SB: begin
                state_q <= READ_WAIT;
                cnt_q   <= '0;
              end
              default: begin
                state_q <= DONE;
                done_q  <= 1'b1;
                error_q <= 1'b1;
              end
            endcase
          end
        end

        READ_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= WRITE;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merge_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Self-checking bench for store_sequencer: directed table, hand-written
// corner sequences, and randomized stores against a word-level memory model.
module tb_store_sequencer;

  localparam int MEM_LAT = 2;
  localparam int BUDGET  = 40;
  localparam int N_RAND  = 150;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] regB;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] wr_cnt;
    logic [31:0] wr_cyc;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] done_cyc;
    logic [31:0] err;
  } exp_t;

  typedef struct {
    logic [31:0] wr_cnt;
    logic [31:0] wr_cyc;
    logic [31:0] wdata;
    logic [31:0] waddr;
    logic [31:0] done_cyc;
    logic [31:0] err;
    logic [31:0] bad_busy;
    logic [31:0] bad_addr;
    logic [31:0] bad_wdata;
    logic [31:0] bad_err;
  } obs_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] regb;
    exp_t        e;
  } vec_t;

  store_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .store_type (store_type),
    .addr       (addr),
    .regB       (regB),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Environment memory (written by the DUT) and the model's own view of memory.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int          rd_age = 0;
  logic        pl_en  = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    if (busy && !mem_wr) rd_age <= rd_age + 1;
    else rd_age <= 0;
  end

  // Read data is valid only once the read address has been held MEM_LAT cycles.
  assign mem_rdata = (rd_age == MEM_LAT - 1) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // One store: start at the next negedge, observe per-cycle outputs until done.
  task automatic exec_store(input logic [1:0] st, input logic [31:0] a, input logic [31:0] b,
                            input bit noise, input bit hold_at_done, output obs_t o);
    o = '{default: '0};
    @(negedge clk);
    start = 1'b1; store_type = st; addr = a; regB = b;
    @(posedge clk);
    #1;
    if (noise) begin
      store_type = 2'($urandom); addr = $urandom; regB = $urandom;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (mem_wr) begin
        o.wr_cnt = o.wr_cnt + 1;
        o.wr_cyc = cyc;
        o.wdata  = mem_wdata;
        o.waddr  = mem_addr;
      end else if (mem_wdata !== 32'h0) begin
        o.bad_wdata = 1;
      end
      if (busy !== 1'b1) o.bad_busy = 1;
      if (mem_addr !== a) o.bad_addr = 1;
      if (error && !done) o.bad_err = 1;
      if (done) begin
        o.done_cyc = cyc;
        o.err      = {31'b0, error};
        break;
      end
      if (noise) begin
        start = 1'b1; store_type = 2'($urandom); addr = $urandom; regB = $urandom;
      end
    end
    if (hold_at_done) begin
      start = 1'b1; store_type = 2'($urandom); addr = $urandom; regB = $urandom;
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic verify(input string tag, input obs_t o, input exp_t e);
    check({tag, " done_cycle"}, o.done_cyc, e.done_cyc);
    check({tag, " write_count"}, o.wr_cnt, e.wr_cnt);
    if (e.wr_cnt == 1) begin
      check({tag, " write_cycle"}, o.wr_cyc, e.wr_cyc);
      check({tag, " wdata"}, o.wdata, e.wdata);
      check({tag, " waddr"}, o.waddr, e.addr);
    end
    check({tag, " error"}, o.err, e.err);
    check({tag, " busy_dropped"}, o.bad_busy, 0);
    check({tag, " addr_not_held"}, o.bad_addr, 0);
    check({tag, " wdata_outside_write"}, o.bad_wdata, 0);
    check({tag, " error_without_done"}, o.bad_err, 0);
  endtask

  // Spec-level model: the word written and the cycle timing for one store.
  function automatic exp_t model(input logic [1:0] st, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] old;
    logic [31:0] keep;
    old  = ref_mem[a[7:2]];
    e    = '{default: '0};
    e.addr = a;
    if (st == 2'd3) begin
      e.done_cyc = 1;
      e.err      = 1;
    end else begin
      keep     = (st == 2'd0) ? 32'h0 : (st == 2'd1) ? 32'hFFFF_0000 : 32'hFFFF_FF00;
      e.wdata  = (old & keep) | (b & ~keep);
      e.wr_cnt = 1;
      e.wr_cyc = (st == 2'd0) ? 1 : MEM_LAT + 1;
      e.done_cyc = e.wr_cyc + 1;
    end
    return e;
  endfunction

  initial begin
    vec_t vecs [8];
    obs_t o;
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  st;
    int          bad;
    bit          hold;

    // Hand-derived expectations; addresses chosen so entries do not disturb each other.
    vecs[0] = '{2'd1, 32'h40, 32'hAAAA_1234, '{1, 3, 32'hDEAD_1234, 32'h40, 4, 0}};
    vecs[1] = '{2'd2, 32'h48, 32'hAAAA_1234, '{1, 3, 32'hDEAD_BE34, 32'h48, 4, 0}};
    vecs[2] = '{2'd0, 32'h4C, 32'hAAAA_1234, '{1, 1, 32'hAAAA_1234, 32'h4C, 2, 0}};
    vecs[3] = '{2'd3, 32'h60, 32'h1234_5678, '{0, 0, 32'h0, 32'h60, 1, 1}};
    vecs[4] = '{2'd1, 32'h50, 32'hFFFF_FFFF, '{1, 3, 32'h0000_FFFF, 32'h50, 4, 0}};
    vecs[5] = '{2'd2, 32'h54, 32'h0000_0000, '{1, 3, 32'hFFFF_FF00, 32'h54, 4, 0}};
    vecs[6] = '{2'd0, 32'h40, 32'hAAAA_1234, '{1, 1, 32'hAAAA_1234, 32'h40, 2, 0}};
    vecs[7] = '{2'd2, 32'h40, 32'h0000_00C3, '{1, 3, 32'hAAAA_12C3, 32'h40, 4, 0}};

    // NOTE: stimulus uses blocking assignments away from the active edge.
    reset = 1'b1; start = 1'b0; store_type = 2'd0; addr = '0; regB = '0;
    #1;
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset flags", {28'b0, mem_wr, busy, done, error}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
    preload(6'h10, 32'hDEAD_BEEF);
    preload(6'h12, 32'hDEAD_BEEF);
    preload(6'h15, 32'hFFFF_FFFF);

    // Entries run back to back: each start lands in the cycle after the previous done.
    for (int i = 0; i < 8; i++) begin
      exec_store(vecs[i].st, vecs[i].addr, vecs[i].regb, 1'b0, 1'b0, o);
      verify($sformatf("vec%0d", i), o, vecs[i].e);
    end
    check("idle keeps mem_addr", mem_addr, 32'h40);

    // start re-pulsed with new operands throughout the read phase is ignored.
    preload(6'h16, 32'hDEAD_BEEF);
    exec_store(2'd1, 32'h58, 32'hAAAA_1234, 1'b1, 1'b0, o);
    verify("ignore_start", o, '{1, 3, 32'hDEAD_1234, 32'h58, 4, 0});
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || mem_wr || busy) bad++;
    end
    check("ignore_start no second op", bad, 0);

    // Reset during the second READ_WAIT cycle aborts the store.
    preload(6'h17, 32'hDEAD_BEEF);
    @(negedge clk);
    start = 1'b1; store_type = 2'd1; addr = 32'h5C; regB = 32'hAAAA_1234;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset mem_addr", mem_addr, 32'h0);
    check("midreset mem_wdata", mem_wdata, 32'h0);
    check("midreset flags", {28'b0, mem_wr, busy, done, error}, 32'h0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr || busy || done) bad++;
    end
    check("midreset quiet", bad, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midreset memory untouched", mem[6'h17], 32'hDEAD_BEEF);
    exec_store(2'd0, 32'h5C, 32'hAAAA_1234, 1'b0, 1'b0, o);
    verify("after_reset_sw", o, '{1, 1, 32'hAAAA_1234, 32'h5C, 2, 0});

    // Randomized stores with operand noise while busy and stray start at done.
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    hold = 1'b0;
    for (int n = 0; n < N_RAND; n++) begin
      st = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      a  = {24'h0, 6'($urandom), 2'b00};
      b  = $urandom;
      e  = model(st, a, b);
      hold = ($urandom_range(0, 3) == 0);
      exec_store(st, a, b, ($urandom_range(0, 1) == 1), hold, o);
      verify($sformatf("rand%0d", n), o, e);
      if (e.wr_cnt == 1) ref_mem[a[7:2]] = e.wdata;
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final memory image", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
